// File: rtl/bus_pkg.sv
// Shared types and constants for the data-memory request router.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef logic [1:0] region_t;

  localparam int unsigned NREGIONS  = 3;
  localparam logic [31:0] ERR_RDATA = '0;

endpackage

// File: rtl/addr_decode3.sv
// Combinational address-to-region decoder; lowest matching region index wins.
module addr_decode3
  import bus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] REGION_MASK = 32'hF000_0000,
  parameter logic [ADDR_W-1:0] R0_BASE     = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] R1_BASE     = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] R2_BASE     = 32'h2000_0000
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output region_t           sel
);

  logic [ADDR_W-1:0] masked;

  always_comb begin
    masked = addr & REGION_MASK;
    hit    = 1'b0;
    sel    = '0;
    if (masked == R0_BASE) begin
      hit = 1'b1;
      sel = 2'd0;
    end else if (masked == R1_BASE) begin
      hit = 1'b1;
      sel = 2'd1;
    end else if (masked == R2_BASE) begin
      hit = 1'b1;
      sel = 2'd2;
    end
  end

endmodule

// File: rtl/bus_demux3.sv
// Single-initiator, three-responder request router with miss and timeout error responses.
module bus_demux3
  import bus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] REGION_MASK = 32'hF000_0000,
  parameter logic [ADDR_W-1:0] R0_BASE     = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] R1_BASE     = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] R2_BASE     = 32'h2000_0000,
  parameter int unsigned       TIMEOUT     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [2:0]              t_valid,
  input  logic [2:0]              t_ready,
  output logic                    t_we,
  output logic [ADDR_W-1:0]       t_addr,
  output logic [DATA_W-1:0]       t_wdata,
  output logic [DATA_W/8-1:0]     t_wstrb,
  input  logic [2:0]              t_rsp_valid,
  input  logic [3*DATA_W-1:0]     t_rsp_rdata,
  input  logic [2:0]              t_rsp_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_RDATA);

  state_t              state;
  region_t             sel;
  logic [CNT_W-1:0]    cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                dec_hit;
  region_t             dec_sel;
  logic                sel_ready;
  logic                sel_rsp_valid;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_err;
  logic                timed_out;

  addr_decode3 #(
    .ADDR_W      (ADDR_W),
    .REGION_MASK (REGION_MASK),
    .R0_BASE     (R0_BASE),
    .R1_BASE     (R1_BASE),
    .R2_BASE     (R2_BASE)
  ) u_decode (
    .addr (req_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  always_comb begin
    sel_ready     = 1'b0;
    sel_rsp_valid = 1'b0;
    sel_rdata     = '0;
    sel_err       = 1'b0;
    case (sel)
      2'd0: begin
        sel_ready     = t_ready[0];
        sel_rsp_valid = t_rsp_valid[0];
        sel_rdata     = t_rsp_rdata[0*DATA_W +: DATA_W];
        sel_err       = t_rsp_err[0];
      end
      2'd1: begin
        sel_ready     = t_ready[1];
        sel_rsp_valid = t_rsp_valid[1];
        sel_rdata     = t_rsp_rdata[1*DATA_W +: DATA_W];
        sel_err       = t_rsp_err[1];
      end
      2'd2: begin
        sel_ready     = t_ready[2];
        sel_rsp_valid = t_rsp_valid[2];
        sel_rdata     = t_rsp_rdata[2*DATA_W +: DATA_W];
        sel_err       = t_rsp_err[2];
      end
      default: ;
    endcase
  end

  // >= rather than == so WAIT still times out after a handshake that landed on the last ISSUE cycle
  assign timed_out = (cnt >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (dec_hit) begin
              sel   <= dec_sel;
              cnt   <= '0;
              state <= ISSUE;
            end else begin
              rdata_q <= ERR_DATA;
              err_q   <= 1'b1;
              state   <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (sel_ready) begin
            state <= WAIT;
          end else if (timed_out) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            state   <= RESP;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (sel_rsp_valid) begin
            rdata_q <= we_q ? ERR_DATA : sel_rdata;
            err_q   <= sel_err;
            state   <= RESP;
          end else if (timed_out) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          // Clearing here keeps every output at zero throughout IDLE
          state   <= IDLE;
          sel     <= '0;
          cnt     <= '0;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          wstrb_q <= '0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign t_valid   = (state == ISSUE) ? (3'b001 << sel) : 3'b000;
  assign t_we      = we_q;
  assign t_addr    = addr_q;
  assign t_wdata   = wdata_q;
  assign t_wstrb   = wstrb_q;

endmodule
